// File: rtl/rc_pkt_checker_if.sv
// Bit-stream input and decoded-packet result bundle for rc_pkt_checker.
interface rc_pkt_checker_if #(
    parameter int MAX_DATA_BYTES = 8
);
    localparam int BCW = $clog2(MAX_DATA_BYTES + 1);

    logic                        s_in;
    logic                        start_rc_crc;
    logic                        end_rc_crc;
    logic                        pkt_rec;
    logic                        pkt_status;
    logic [7:0]                  rc_pid;
    logic [10:0]                 rc_token;
    logic [MAX_DATA_BYTES*8-1:0] rc_data;
    logic [BCW-1:0]              rc_byte_count;
    logic                        rc_CRCerror;
    logic                        rc_pid_error;
    logic                        rc_len_error;
    logic                        rc_overrun;

    modport master (
        output s_in, start_rc_crc, end_rc_crc, pkt_rec,
        input  pkt_status, rc_pid, rc_token, rc_data, rc_byte_count,
               rc_CRCerror, rc_pid_error, rc_len_error, rc_overrun
    );

    modport slave (
        input  s_in, start_rc_crc, end_rc_crc, pkt_rec,
        output pkt_status, rc_pid, rc_token, rc_data, rc_byte_count,
               rc_CRCerror, rc_pid_error, rc_len_error, rc_overrun
    );
endinterface

// File: rtl/rc_pkt_checker.sv
// Serial packet checker: captures PID/token/data from a decoded bit stream and
// reports length, PID and CRC errors one clock after the last packet bit.
module rc_pkt_checker #(
    parameter int MAX_DATA_BYTES = 8,
    parameter bit CHECK_PID      = 1'b1
) (
    input logic             clk,
    input logic             rst,
    rc_pkt_checker_if.slave bus
);
    localparam int DW   = MAX_DATA_BYTES * 8;
    localparam int BUFW = DW + 16;
    localparam int BIW  = $clog2(BUFW);
    localparam int CMAX = BUFW + 9;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BCW  = $clog2(MAX_DATA_BYTES + 1);

    localparam logic [CW-1:0] N_PID  = CW'(8);
    localparam logic [CW-1:0] N_TOK  = CW'(24);
    localparam logic [CW-1:0] N_SAT  = CW'(CMAX);
    localparam logic [CW-1:0] N_BUF  = CW'(BUFW);
    localparam logic [CW-1:0] N_MAXB = CW'(MAX_DATA_BYTES);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0]      pid;
    logic [BUFW-1:0] buf_q;
    logic [4:0]      crc5;
    logic [15:0]     crc16;
    logic [BCW-1:0]  byte_cnt;
    logic            status, crc_err, pid_err, len_err, overrun;

    logic [CW-1:0]   cnt_nxt, post_idx, n_len, dlen;
    logic [BIW-1:0]  wr_idx;
    logic [7:0]      pid_fin;
    logic [4:0]      crc5_nxt, crc5_fin;
    logic [15:0]     crc16_nxt, crc16_fin;
    logic            in_pid, store_buf;
    logic            e_len, e_crc, e_pid;
    logic [BCW-1:0]  e_bc;

    // Verdict for a packet whose last bit is on s_in this cycle.
    always_comb begin
        cnt_nxt   = (cnt == N_SAT) ? cnt : cnt + CW'(1);
        in_pid    = cnt < N_PID;
        post_idx  = cnt - N_PID;
        wr_idx    = post_idx[BIW-1:0];
        store_buf = !in_pid && (post_idx < N_BUF);
        crc5_nxt  = {crc5[3:0], 1'b0} ^ ({5{crc5[4] ^ bus.s_in}} & 5'h05);
        crc16_nxt = {crc16[14:0], 1'b0} ^ ({16{crc16[15] ^ bus.s_in}} & 16'h8005);
        pid_fin   = pid;
        if (in_pid) pid_fin[cnt[2:0]] = bus.s_in;
        crc5_fin  = in_pid ? crc5 : crc5_nxt;
        crc16_fin = in_pid ? crc16 : crc16_nxt;
        n_len     = cnt_nxt;
        dlen      = n_len - N_TOK;
        e_len     = 1'b0;
        e_crc     = 1'b0;
        e_bc      = '0;
        if (n_len < N_PID) begin
            e_len = 1'b1;
        end else begin
            case (pid_fin[1:0])
                2'b01: begin
                    e_len = (n_len != N_TOK);
                    e_crc = (crc5_fin != 5'b01100);
                end
                2'b11: begin
                    if (n_len >= N_TOK && dlen[2:0] == 3'd0 && (dlen >> 3) <= N_MAXB)
                        e_bc = BCW'(dlen >> 3);
                    else
                        e_len = 1'b1;
                    e_crc = (crc16_fin != 16'h800D);
                end
                default: e_len = (n_len != N_PID);
            endcase
        end
        e_pid = CHECK_PID && ((n_len < N_PID) || (pid_fin[7:4] != ~pid_fin[3:0]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pid      <= '0;
            buf_q    <= '0;
            crc5     <= 5'h1F;
            crc16    <= 16'hFFFF;
            byte_cnt <= '0;
            status   <= 1'b0;
            crc_err  <= 1'b0;
            pid_err  <= 1'b0;
            len_err  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_rc_crc) begin
                        pid      <= {7'd0, bus.s_in};
                        buf_q    <= '0;
                        cnt      <= CW'(1);
                        crc5     <= 5'h1F;
                        crc16    <= 16'hFFFF;
                        byte_cnt <= '0;
                        crc_err  <= 1'b0;
                        overrun  <= 1'b0;
                        // A one-bit packet completes in the same cycle it starts.
                        if (bus.end_rc_crc) begin
                            state   <= DONE;
                            status  <= 1'b1;
                            len_err <= 1'b1;
                            pid_err <= CHECK_PID;
                        end else begin
                            state   <= RECV;
                            len_err <= 1'b0;
                            pid_err <= 1'b0;
                        end
                    end
                end
                RECV: begin
                    if (bus.start_rc_crc) overrun <= 1'b1;
                    cnt <= cnt_nxt;
                    pid <= pid_fin;
                    if (store_buf) buf_q[wr_idx] <= bus.s_in;
                    if (!in_pid) begin
                        crc5  <= crc5_nxt;
                        crc16 <= crc16_nxt;
                    end
                    if (bus.end_rc_crc) begin
                        state    <= DONE;
                        status   <= 1'b1;
                        crc_err  <= e_crc;
                        len_err  <= e_len;
                        pid_err  <= e_pid;
                        byte_cnt <= e_bc;
                    end
                end
                DONE: begin
                    if (bus.start_rc_crc) overrun <= 1'b1;
                    if (bus.pkt_rec) begin
                        state  <= IDLE;
                        status <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pkt_status    = status;
    assign bus.rc_pid        = pid;
    assign bus.rc_token      = buf_q[10:0];
    assign bus.rc_byte_count = byte_cnt;
    assign bus.rc_CRCerror   = crc_err;
    assign bus.rc_pid_error  = pid_err;
    assign bus.rc_len_error  = len_err;
    assign bus.rc_overrun    = overrun;

    // Bytes beyond the reported payload length read as zero.
    for (genvar k = 0; k < MAX_DATA_BYTES; k++) begin : g_data
        assign bus.rc_data[8*k +: 8] = (BCW'(k) < byte_cnt) ? buf_q[8*k +: 8] : 8'h00;
    end
endmodule

// File: doc/rc_pkt_checker.md
RC_PKT_CHECKER -- requirements
Module: rc_pkt_checker

Interface
REQ-001 SHALL have parameter MAX_DATA_BYTES, default 8, giving the largest DATA payload captured, legal range 1..64.
REQ-002 SHALL have parameter CHECK_PID, default 1; when 1 the PID check-field comparison is enabled, when 0 rc_pid_error is tied to 0.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 SHALL have port s_in, input, 1 bit, the unstuffed, NRZI-decoded serial bit, LSB-first, one bit per clk.
REQ-006 SHALL have port start_rc_crc, input, 1 bit, high in the cycle s_in carries the first PID bit.
REQ-007 SHALL have port end_rc_crc, input, 1 bit, high in the cycle s_in carries the last packet bit.
REQ-008 SHALL have port pkt_rec, input, 1 bit, the consumer acknowledge of a RECEIVED packet.
REQ-009 SHALL have port pkt_status, output, 1 bit: 0 = PROCESSING, 1 = RECEIVED.
REQ-010 SHALL have port rc_pid, output, 8 bits, the captured PID byte.
REQ-011 SHALL have port rc_token, output, 11 bits, token address in [6:0] and endpoint in [10:7].
REQ-012 SHALL have port rc_data, output, MAX_DATA_BYTES*8 bits; byte k is at [8k+7:8k], first received bit is the LSB.
REQ-013 SHALL have port rc_byte_count, output, $clog2(MAX_DATA_BYTES+1) bits, the number of DATA payload bytes.
REQ-014 SHALL have ports rc_CRCerror, rc_pid_error, rc_len_error and rc_overrun, each output, 1 bit, the error flags.

Function
REQ-015 SHALL implement FSM states IDLE, RECV and DONE.
REQ-016 IDLE: start_rc_crc=1 SHALL load bit 0 of the PID, clear all flags and clear the bit counter, then go to RECV.
REQ-017 RECV: each cycle SHALL store s_in at the running bit index and increment the bit counter.
REQ-018 RECV: end_rc_crc=1 SHALL store the last bit and enter DONE on the next edge.
REQ-019 pkt_status SHALL be 1 exactly while in DONE, so all outputs are valid one clk after the last bit.
REQ-020 DONE: pkt_rec=1 SHALL return the FSM to IDLE on the next edge and drop pkt_status to 0.
REQ-021 DONE: outputs SHALL hold stable until pkt_rec is sampled high.
REQ-022 The first 8 bits SHALL form rc_pid; packet type is rc_pid[1:0]: 10 handshake, 01 token, 11 data, 00 special (treated as handshake).
REQ-023 With CHECK_PID=1, rc_pid_error SHALL be set when rc_pid[7:4] != ~rc_pid[3:0].
REQ-024 Handshake packets SHALL have exactly 8 bits; any other length sets rc_len_error.
REQ-025 Token packets SHALL have exactly 24 bits; otherwise rc_len_error.
REQ-026 Token CRC5 SHALL use polynomial x^5+x^2+1, seed 5'b11111, run over post-PID bits including the CRC; a remainder other than 5'b01100 sets rc_CRCerror.
REQ-027 Data packets SHALL have L post-PID bits with L >= 16, (L-16) divisible by 8, and (L-16)/8 <= MAX_DATA_BYTES; otherwise rc_len_error is set.
REQ-028 Data packet storage SHALL stop at MAX_DATA_BYTES*8+16 bits, so no overwrite or wrap occurs.
REQ-029 Data CRC16 SHALL use polynomial x^16+x^15+x^2+1, seed 16'hFFFF, run serially over payload and CRC; a remainder other than 16'h800D sets rc_CRCerror.
REQ-030 rc_byte_count SHALL be (L-16)/8 for a legal data packet, else 0.
REQ-031 rc_data bits at or above 8*rc_byte_count SHALL read 0.
REQ-032 Packets shorter than 8 bits SHALL set rc_len_error and rc_pid_error; CRC SHALL NOT be evaluated.
REQ-033 If start_rc_crc and end_rc_crc are both high in the same cycle, the packet is 1 bit long; REQ-032 SHALL apply.
REQ-034 start_rc_crc in RECV or DONE SHALL be ignored and SHALL set sticky rc_overrun, which clears only at the next accepted start.
REQ-035 rc_CRCerror SHALL be 0 for handshake packets.

Reset
REQ-036 rst=1 at any time, including mid-packet, SHALL force IDLE immediately.
REQ-037 During and after reset, pkt_status=0, all data outputs 0, all flags 0, bit counter 0, and CRC registers at seed.
REQ-038 The first start_rc_crc after rst deasserts SHALL be accepted normally.

Verification
REQ-039 ACK handshake: bits 0,1,0,0,1,0,1,1 -> pkt_status=1 one clk after end; rc_pid=8'hD2, all flags 0, rc_byte_count=0.
REQ-040 DATA0 zero-length: PID 8'hC3 followed by 16 zero bits (CRC16 of empty payload = 16'h0000) -> rc_CRCerror=0, rc_len_error=0, rc_byte_count=0.
REQ-041 DATA0 with 8 payload bytes, CRC from the bench model -> rc_byte_count=8 and rc_data equal to the payload.
REQ-042 Repeating REQ-041 with one payload bit flipped -> rc_CRCerror=1.
REQ-043 SETUP token with addr=7'h15, endp=4'hE and model CRC5 -> rc_token=11'h715 and no flags.
REQ-044 A packet of 20 post-PID data bits -> rc_len_error=1; a start_rc_crc in DONE -> rc_overrun=1.
REQ-045 Asserting rst mid-packet -> IDLE and all outputs 0; pkt_rec held in DONE -> pkt_status=0 on the next edge.
